// File: rtl/llm_pkg.sv
// Shared types and width rules for the gather stage that re-merges the
// large/small outlier-decomposed streams.
package llm_pkg;

  localparam int DEF_IN_WIDTH       = 16;
  localparam int DEF_IN_SIZE        = 4;
  localparam int DEF_IN_PARALLELISM = 1;
  localparam int DEF_IN_N           = DEF_IN_SIZE * DEF_IN_PARALLELISM;

  // One extra bit holds the sum of two signed elements without overflow.
  function automatic int out_width_of(input int in_width);
    return in_width + 1;
  endfunction

  localparam int DEF_OUT_WIDTH = out_width_of(DEF_IN_WIDTH);

  typedef logic [DEF_IN_N-1:0][DEF_IN_WIDTH-1:0]  gather_beat_t;
  typedef logic [DEF_IN_N-1:0][DEF_OUT_WIDTH-1:0] gather_sum_t;

endpackage

// File: rtl/gather_fifo.sv
// Synchronous skew-absorbing FIFO for one input stream of the gather stage.
// Ready is a register reflecting occupancy only, so it never depends on valid.
module gather_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_en
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && rd_valid;
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      // A pop while full frees a slot, but ready only rises on the following cycle.
      wr_ready <= (count_next != CW'(DEPTH));
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written, so reset logic there buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gather.sv
// Joins the large and small streams beat by beat into a registered sum stream
// with a tensor beat counter. Define GATHER_OVERLAP_CHECK_EN to add overlap_err.
module gather
  import llm_pkg::*;
#(
  parameter  int IN_WIDTH       = DEF_IN_WIDTH,
  parameter  int IN_SIZE        = DEF_IN_SIZE,
  parameter  int IN_PARALLELISM = DEF_IN_PARALLELISM,
  parameter  int IN_DEPTH       = 8,
  parameter  int FIFO_DEPTH     = 2,
  localparam int OUT_WIDTH      = out_width_of(IN_WIDTH),
  localparam int N              = IN_SIZE * IN_PARALLELISM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0][IN_WIDTH-1:0]    data_in_large,
  input  logic                          data_in_large_valid,
  output logic                          data_in_large_ready,
  input  logic [N-1:0][IN_WIDTH-1:0]    data_in_small,
  input  logic                          data_in_small_valid,
  output logic                          data_in_small_ready,
  output logic [N-1:0][OUT_WIDTH-1:0]   data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          data_out_last
`ifdef GATHER_OVERLAP_CHECK_EN
  ,
  output logic                          overlap_err
`endif
);

  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  logic [N-1:0][IN_WIDTH-1:0]  head_large;
  logic [N-1:0][IN_WIDTH-1:0]  head_small;
  logic                        head_large_valid;
  logic                        head_small_valid;
  logic                        join_fire;
  logic                        out_fire;
  logic [N-1:0][OUT_WIDTH-1:0] sum;
  logic [CNT_W-1:0]            beat_count;

  gather_fifo #(
    .WIDTH (N * IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_large (
    .clk      (clk),
    .rst_n    (rst),
    .wr_data  (data_in_large),
    .wr_valid (data_in_large_valid),
    .wr_ready (data_in_large_ready),
    .rd_data  (head_large),
    .rd_valid (head_large_valid),
    .rd_en    (join_fire)
  );

  gather_fifo #(
    .WIDTH (N * IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_small (
    .clk      (clk),
    .rst_n    (rst),
    .wr_data  (data_in_small),
    .wr_valid (data_in_small_valid),
    .wr_ready (data_in_small_ready),
    .rd_data  (head_small),
    .rd_valid (head_small_valid),
    .rd_en    (join_fire)
  );

  // Both heads leave together so the streams can never slip out of pairing.
  assign out_fire  = data_out_valid && data_out_ready;
  assign join_fire = head_large_valid && head_small_valid &&
                     (!data_out_valid || data_out_ready);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum[k] = {head_large[k][IN_WIDTH-1], head_large[k]} +
               {head_small[k][IN_WIDTH-1], head_small[k]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else if (join_fire) begin
      data_out       <= sum;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count <= '0;
    end else if (out_fire) begin
      beat_count <= (beat_count == LAST_BEAT) ? '0 : beat_count + CNT_W'(1);
    end
  end

  assign data_out_last = data_out_valid && (beat_count == LAST_BEAT);

`ifdef GATHER_OVERLAP_CHECK_EN
  logic overlap_hit;

  // Scatter guarantees each element lives in exactly one stream.
  always_comb begin
    overlap_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if ((|head_large[k]) && (|head_small[k])) overlap_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overlap_err <= 1'b0;
    end else if (join_fire && overlap_hit) begin
      overlap_err <= 1'b1;
    end
  end
`endif

endmodule
